// File: rtl/admo_id_ex_stage.sv
// rtl/admo_id_ex_stage.sv - ID/EX register with forwarding, load-use interlock and stall counter
// Define ADMO_ID_EX_FWD_EN for EX/WB operand forwarding; otherwise RAW hazards stall until clear.
module admo_id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
    input  logic [DATA_WIDTH-1:0] id_imm_i,
    input  logic                  id_use_pc_i,
    input  logic                  id_use_imm_i,
    input  logic [3:0]            id_alu_op_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_rd_we_i,
    input  logic                  id_is_load_i,
    input  logic [DATA_WIDTH-1:0] ex_fwd_data_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [DATA_WIDTH-1:0] ex_operand_a_o,
    output logic [DATA_WIDTH-1:0] ex_operand_b_o,
    output logic [3:0]            ex_alu_op_o,
    output logic [DATA_WIDTH-1:0] ex_store_data_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic                  ex_rd_we_o,
    output logic                  ex_is_load_o,
    output logic [31:0]           stall_cnt_o
);

    logic                  held_match_rs1;
    logic                  held_match_rs2;
    logic                  wb_match_rs1;
    logic                  wb_match_rs2;
    logic                  hazard;
    logic                  accept;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // A nonzero rd is required, so index 0 can never match a source.
    assign held_match_rs1 = ex_valid_o && ex_rd_we_o && (ex_rd_addr_o != '0)
                            && (ex_rd_addr_o == id_rs1_addr_i);
    assign held_match_rs2 = ex_valid_o && ex_rd_we_o && (ex_rd_addr_o != '0)
                            && (ex_rd_addr_o == id_rs2_addr_i);
    assign wb_match_rs1   = wb_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs1_addr_i);
    assign wb_match_rs2   = wb_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs2_addr_i);

`ifdef ADMO_ID_EX_FWD_EN
    // Load results only exist at WB, so a load in EX must interlock instead of forwarding.
    assign hazard = ex_is_load_o && (held_match_rs1 || held_match_rs2);

    always_comb begin
        fwd_rs1 = id_rs1_data_i;
        if (held_match_rs1 && !ex_is_load_o) begin
            fwd_rs1 = ex_fwd_data_i;
        end else if (wb_match_rs1) begin
            fwd_rs1 = wb_data_i;
        end
    end

    always_comb begin
        fwd_rs2 = id_rs2_data_i;
        if (held_match_rs2 && !ex_is_load_o) begin
            fwd_rs2 = ex_fwd_data_i;
        end else if (wb_match_rs2) begin
            fwd_rs2 = wb_data_i;
        end
    end
`else
    // Without bypass paths, any in-flight writer of a source must retire to the register file first.
    logic unused_bypass_data;

    assign unused_bypass_data = ^{ex_fwd_data_i, wb_data_i};
    assign hazard  = held_match_rs1 || held_match_rs2 || wb_match_rs1 || wb_match_rs2;
    assign fwd_rs1 = id_rs1_data_i;
    assign fwd_rs2 = id_rs2_data_i;
`endif

    assign id_ready_o = (!ex_valid_o || ex_ready_i) && !hazard && !flush_i;
    assign accept     = id_valid_i && id_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_o      <= 1'b0;
            ex_operand_a_o  <= '0;
            ex_operand_b_o  <= '0;
            ex_alu_op_o     <= '0;
            ex_store_data_o <= '0;
            ex_rd_addr_o    <= '0;
            ex_rd_we_o      <= 1'b0;
            ex_is_load_o    <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (accept) begin
            ex_valid_o      <= 1'b1;
            ex_operand_a_o  <= id_use_pc_i ? id_pc_i : fwd_rs1;
            ex_operand_b_o  <= id_use_imm_i ? id_imm_i : fwd_rs2;
            ex_alu_op_o     <= id_alu_op_i;
            ex_store_data_o <= fwd_rs2;
            ex_rd_addr_o    <= id_rd_addr_i;
            ex_rd_we_o      <= id_rd_we_i;
            ex_is_load_o    <= id_is_load_i;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (id_valid_i && hazard && !flush_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: doc/admo_id_ex_stage.md
Name: admo_id_ex_stage

Overview:
- Decode-to-execute pipeline stage sitting directly upstream of the integer ALU.
- Registers one decoded instruction and resolves RAW hazards by forwarding from the EX result and WB ports.
- Selects ALU operand A (rs1 or PC) and operand B (rs2 or immediate), and presents operand_a/operand_b/4-bit operator to the ALU.
- Provides valid/ready handshake, flush, load-use interlock and a stall counter.

Parameters:
DATA_WIDTH, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  kill held and incoming instruction (branch/exception)
id_valid_i  in  1  decode has an instruction
id_ready_o  out  1  stage accepts instruction this cycle
id_pc_i  in  DATA_WIDTH  instruction PC
id_rs1_addr_i  in  REG_ADDR_W  source 1 index
id_rs2_addr_i  in  REG_ADDR_W  source 2 index
id_rs1_data_i  in  DATA_WIDTH  register-file rs1 value
id_rs2_data_i  in  DATA_WIDTH  register-file rs2 value
id_imm_i  in  DATA_WIDTH  sign-extended immediate
id_use_pc_i  in  1  operand A = PC
id_use_imm_i  in  1  operand B = immediate
id_alu_op_i  in  4  ALU operator code (passed unmodified)
id_rd_addr_i  in  REG_ADDR_W  destination index
id_rd_we_i  in  1  instruction writes rd
id_is_load_i  in  1  instruction is a load
ex_fwd_data_i  in  DATA_WIDTH  ALU result of the instruction currently held
wb_we_i  in  1  writeback valid
wb_rd_addr_i  in  REG_ADDR_W  writeback index
wb_data_i  in  DATA_WIDTH  writeback data (includes load data)
ex_valid_o  out  1  held instruction valid
ex_ready_i  in  1  downstream consumes held instruction
ex_operand_a_o  out  DATA_WIDTH  ALU operand A
ex_operand_b_o  out  DATA_WIDTH  ALU operand B
ex_alu_op_o  out  4  ALU operator
ex_store_data_o  out  DATA_WIDTH  forwarded rs2 value (store data)
ex_rd_addr_o  out  REG_ADDR_W  destination index
ex_rd_we_o  out  1  destination write enable
ex_is_load_o  out  1  held instruction is a load
stall_cnt_o  out  32  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, rst_ni=0): ex_valid_o=0, all ex_* data/control outputs=0, stall_cnt_o=0. Reset mid-transfer drops the held instruction.
- Transfer: accept when id_valid_i && id_ready_o. Outputs are registered; latency ID to EX is 1 cycle.
- id_ready_o = (!ex_valid_o || ex_ready_i) && !hazard && !flush_i. It is combinational and does not depend on id_valid_i.
- Hold: ex_valid_o && !ex_ready_i keeps all ex_* outputs stable.
- Bubble: ex_ready_i=1 with no accept gives ex_valid_o=0 next cycle.
- Flush has priority over accept: ex_valid_o=0 next cycle, incoming instruction discarded.
- Forwarding per source rsN, priority order:
  (1) EX: ex_valid_o && ex_rd_we_o && !ex_is_load_o && ex_rd_addr_o==rsN, using ex_fwd_data_i.
  (2) WB: wb_we_i && wb_rd_addr_i==rsN, using wb_data_i.
  (3) Register-file data.
- Index 0 is never forwarded; it always reads id_rsN_data_i.
- Load-use hazard = ex_valid_o && ex_is_load_o && ex_rd_we_o && ex_rd_addr_o!=0 && (ex_rd_addr_o==id_rs1_addr_i || ex_rd_addr_o==id_rs2_addr_i). While it holds, id_ready_o=0. Once the load leaves, the hazard clears and the load data arrives through wb_* in that cycle.
- Operand A = id_use_pc_i ? id_pc_i : fwd_rs1. Operand B = id_use_imm_i ? id_imm_i : fwd_rs2. ex_store_data_o = fwd_rs2 always.
- stall_cnt_o increments each cycle id_valid_i && hazard && !flush_i, and saturates at 0xFFFFFFFF.
- Simultaneous WB and EX match: EX wins. WB to x0 is ignored.

Optional Feature:
- Macro: ADMO_ID_EX_FWD_EN.
- Defined: forwarding as specified above.
- Undefined: no forwarding muxes; operands come from register-file data only.
  - hazard additionally asserts when a valid held writer (any type, rd!=0) matches rs1/rs2.
  - hazard also asserts when wb_we_i matches rs1/rs2 (rd!=0).
  - Stalls count in stall_cnt_o.

Test Plan:
- Reset with id_valid_i=1 -> ex_valid_o=0, stall_cnt_o=0, id_ready_o=1 after release.
- ADD x3 (rd=3, result 0x10) followed by ADD rs1=x3, ex_fwd_data_i=0x10, ex_ready_i=1 -> next cycle ex_operand_a_o=0x10, stall_cnt_o unchanged.
- LW x5 held, next instruction rs2=x5 -> id_ready_o=0 one cycle, stall_cnt_o=1. Then wb_data_i=0xDEADBEEF to x5 -> ex_operand_b_o=0xDEADBEEF.
- ex_ready_i=0 for 3 cycles with id_valid_i=1 -> ex_* outputs unchanged, id_ready_o=0, stall_cnt_o unchanged.
- flush_i=1 coincident with accept -> ex_valid_o=0 next cycle, instruction not emitted.
- rs1=x0 with wb_we_i=1, wb_rd_addr_i=0, wb_data_i=0x55 -> ex_operand_a_o=id_rs1_data_i (0). With the macro undefined, the RAW case from scenario 2 stalls until the writer leaves WB.
